// File: rtl/aes_output_buffer.sv
// aes_output_buffer
//   Output stage of the AES encryption pipeline. Finished 128-bit ciphertext
//   blocks go into a DEPTH-entry FIFO. o_is_full holds the upstream pipeline.
//   Each stored block is sent on an OUT_WIDTH valid/ready stream, most
//   significant word first.
//   Optional feature macro: AES_OBUF_STATS_EN adds o_block_count, which is a
//   saturating count of fully drained blocks.
module aes_output_buffer #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned OUT_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_data_done,
   input  logic [127:0]               i_data_output,
   output logic                       o_is_full,
   output logic [OUT_WIDTH-1:0]       o_dout,
   output logic                       o_dout_valid,
   input  logic                       i_dout_ready,
   output logic                       o_dout_last,
   output logic [$clog2(DEPTH):0]     o_count
`ifdef AES_OBUF_STATS_EN
   ,
   output logic [15:0]                o_block_count
`endif
);

   localparam int unsigned W  = 128 / OUT_WIDTH;
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [127:0]          r_mem [DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic [IW-1:0]         r_idx;
   logic                  r_full;

   logic                  w_valid;
   logic                  w_wr;
   logic                  w_xfer;
   logic                  w_pop;
   logic [127:0]          w_head;
   logic [OUT_WIDTH-1:0]  w_word;
   logic [CW-1:0]         w_count_nxt;

   assign w_valid = (r_count != '0);
   assign w_wr    = i_data_done && !r_full;
   assign w_xfer  = w_valid && i_dout_ready;
   assign w_pop   = w_xfer && (r_idx == LAST_IDX);
   assign w_head  = r_mem[r_rd_ptr];

   // Next occupancy: a write and a pop in the same cycle cancel out
   always_comb begin
      w_count_nxt = r_count;
      if (w_wr && !w_pop)
         w_count_nxt = r_count + 1'b1;
      else if (!w_wr && w_pop)
         w_count_nxt = r_count - 1'b1;
   end

   // Select the current word of the head block (index 0 = most significant)
   always_comb begin
      w_word = '0;
      for (int unsigned k = 0; k < W; k++) begin
         if (r_idx == IW'(k))
            w_word = w_head[128 - OUT_WIDTH*(k+1) +: OUT_WIDTH];
      end
   end

   // FIFO storage; the contents need no reset because valid masks them
   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wr_ptr] <= i_data_output;
   end

   // Pointers, occupancy, registered full flag and word index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_idx    <= '0;
         r_full   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == FULL_CNT);
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_xfer) begin
            if (r_idx == LAST_IDX) begin
               r_idx    <= '0;
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end
      end
   end

`ifdef AES_OBUF_STATS_EN
   logic [15:0] r_block_count;

   // Saturating count of fully drained blocks
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_block_count <= '0;
      else if (w_pop && (r_block_count != '1))
         r_block_count <= r_block_count + 1'b1;
   end

   assign o_block_count = r_block_count;
`endif

   assign o_is_full    = r_full;
   assign o_count      = r_count;
   assign o_dout_valid = w_valid;
   assign o_dout       = w_valid ? w_word : '0;
   assign o_dout_last  = w_valid && (r_idx == LAST_IDX);

endmodule

// File: tb/tb_aes_output_buffer.sv
// tb_aes_output_buffer
//   Directed scenarios plus randomized traffic checked against a queue-based
//   reference model of the output buffer.
module tb_aes_output_buffer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned OW    = 32;
   localparam int unsigned W     = 128 / OW;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            i_data_done = 1'b0;
   logic [127:0]    i_data_output = '0;
   logic            o_is_full;
   logic [OW-1:0]   o_dout;
   logic            o_dout_valid;
   logic            i_dout_ready = 1'b0;
   logic            o_dout_last;
   logic [CW-1:0]   o_count;
`ifdef AES_OBUF_STATS_EN
   logic [15:0]     o_block_count;
`endif

   always #5 clk = ~clk;

   aes_output_buffer #(.DEPTH(DEPTH), .OUT_WIDTH(OW)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_data_done   (i_data_done),
      .i_data_output (i_data_output),
      .o_is_full     (o_is_full),
      .o_dout        (o_dout),
      .o_dout_valid  (o_dout_valid),
      .i_dout_ready  (i_dout_ready),
      .o_dout_last   (o_dout_last),
      .o_count       (o_count)
`ifdef AES_OBUF_STATS_EN
      ,
      .o_block_count (o_block_count)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model: queue of stored blocks, word position in the head block
   logic [127:0] q[$];
   int           m_idx  = 0;
   bit           m_full = 1'b0;
   int           m_pops = 0;

   function automatic logic [OW-1:0] exp_word();
      if (q.size() == 0) return '0;
      return OW'(q[0] >> ((W - 1 - m_idx) * OW));
   endfunction

   task automatic check_outputs();
      bit v;
      v = (q.size() != 0);
      check_val("valid", o_dout_valid, v);
      check_val("dout", o_dout, exp_word());
      check_val("last", o_dout_last, v && (m_idx == W - 1));
      check_val("count", o_count, q.size());
      check_val("full", o_is_full, m_full);
`ifdef AES_OBUF_STATS_EN
      check_val("blk_cnt", o_block_count, (m_pops > 65535) ? 65535 : m_pops);
`endif
   endtask

   // One clock: update the model from the inputs present at the edge, then check
   task automatic step();
      bit wr;
      bit xfer;
      @(posedge clk);
      wr   = i_data_done && !m_full;
      xfer = (q.size() != 0) && i_dout_ready;
      if (xfer) begin
         if (m_idx == W - 1) begin
            void'(q.pop_front());
            m_idx = 0;
            m_pops++;
         end else begin
            m_idx++;
         end
      end
      if (wr) q.push_back(i_data_output);
      m_full = (q.size() == DEPTH);
      #1;
      check_outputs();
   endtask

   // Asynchronous reset in mid-cycle; outputs must clear without a clock edge
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      check_val("rst_valid", o_dout_valid, 1'b0);
      check_val("rst_dout", o_dout, '0);
      check_val("rst_last", o_dout_last, 1'b0);
      check_val("rst_count", o_count, '0);
      check_val("rst_full", o_is_full, 1'b0);
`ifdef AES_OBUF_STATS_EN
      check_val("rst_blk_cnt", o_block_count, '0);
`endif
      q.delete();
      m_idx  = 0;
      m_full = 1'b0;
      m_pops = 0;
      i_data_done  = 1'b0;
      i_dout_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic push_block(input logic [127:0] d);
      i_data_done   = 1'b1;
      i_data_output = d;
      step();
      i_data_done   = 1'b0;
   endtask

   task automatic drain_all();
      int budget;
      budget = 200;
      i_data_done  = 1'b0;
      i_dout_ready = 1'b1;
      while (q.size() != 0 && budget > 0) begin
         step();
         budget--;
      end
      check_val("drain_done", q.size() == 0, 1'b1);
      i_dout_ready = 1'b0;
   endtask

   logic [OW-1:0] exp_words [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

   initial begin
      // Reset
      do_reset();

      // Single block with known words
      i_dout_ready = 1'b1;
      check_val("t2_pre_valid", o_dout_valid, 1'b0);
      push_block(128'h00112233_44556677_8899AABB_CCDDEEFF);
      for (int i = 0; i < 4; i++) begin
         check_val("t2_word", o_dout, exp_words[i]);
         check_val("t2_last", o_dout_last, (i == 3));
         step();
      end
      check_val("t2_count_end", o_count, '0);

      // Fill, hold a fifth block while full, then release it with one pop
      i_dout_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         push_block({4{$urandom}});
      check_val("t3_full", o_is_full, 1'b1);
      i_data_done   = 1'b1;
      i_data_output = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 3; i++) begin
         step();
         check_val("t3_hold_count", o_count, 4);
      end
      i_dout_ready = 1'b1;
      for (int i = 0; i < W; i++) step();
      check_val("t3_pop_count", o_count, 3);
      check_val("t3_pop_full", o_is_full, 1'b0);
      i_dout_ready = 1'b0;
      step();
      check_val("t3_late_wr_count", o_count, 4);
      check_val("t3_late_wr_full", o_is_full, 1'b1);
      i_data_done = 1'b0;
      drain_all();

      // Backpressure: alternating ready across two blocks
      push_block({$urandom, $urandom, $urandom, $urandom});
      push_block({$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i < 20; i++) begin
         i_dout_ready = (i % 2 == 0);
         step();
      end
      drain_all();

      // Concurrent write and last-word pop at count 2
      push_block({$urandom, $urandom, $urandom, $urandom});
      push_block({$urandom, $urandom, $urandom, $urandom});
      i_dout_ready = 1'b1;
      for (int i = 0; i < W - 1; i++) step();
      check_val("t5_at_last", o_dout_last, 1'b1);
      push_block({$urandom, $urandom, $urandom, $urandom});
      check_val("t5_count", o_count, 2);
      drain_all();

      // Random traffic with a reset partway through
      for (int c = 0; c < 600; c++) begin
         bit wr;
         if (c == 300) do_reset();
         if (!i_data_done && $urandom_range(0, 2) == 0) begin
            i_data_done   = 1'b1;
            i_data_output = {$urandom, $urandom, $urandom, $urandom};
         end
         i_dout_ready = ($urandom_range(0, 3) != 0);
         wr = i_data_done && !m_full;
         step();
         if (wr) i_data_done = 1'b0;
      end
      i_data_done = 1'b0;
      drain_all();

`ifdef AES_OBUF_STATS_EN
      do_reset();
      for (int i = 0; i < 3; i++) push_block({$urandom, $urandom, $urandom, $urandom});
      drain_all();
      check_val("t6_three", o_block_count, 3);
      @(negedge clk);
      force dut.r_block_count = 16'hFFFF;
      @(negedge clk);
      release dut.r_block_count;
      m_pops = 65535;
      push_block({$urandom, $urandom, $urandom, $urandom});
      drain_all();
      check_val("t6_sat", o_block_count, 16'hFFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
